// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ack bus between the fetch stage (master) and memory (slave).
interface fetch_unit_if #(parameter int XLEN = 32);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches over a req/ack bus and hands one instruction at a time to decode.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   fetch_unit_if.master    imem,
   input  logic            br_taken_i,
   input  logic [XLEN-1:0] br_target_i,
   input  logic            stall_i,
   output logic [XLEN-1:0] instr_o,
   output logic            instr_valid_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic [XLEN-1:0] r15_o
);
   typedef enum logic [1:0] {IDLE, REQ, DELIVER} state_t;
   state_t          state_q;
   logic [XLEN-1:0] pc_q, req_addr_q, pend_q, pend_pc_q, instr_q, instr_pc_q;
   logic            kill_q, imem_req_q, instr_valid_q;
   logic [XLEN-1:0] tgt;
   assign tgt           = br_target_i & ~XLEN'(3);
   assign imem.imem_req  = imem_req_q;
   assign imem.imem_addr = req_addr_q;
   assign instr_o       = instr_q;
   assign instr_valid_o = instr_valid_q;
   assign instr_pc_o    = instr_pc_q;
   assign r15_o         = instr_pc_q + XLEN'(8);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         req_addr_q    <= RESET_PC;
         kill_q        <= 1'b0;
         imem_req_q    <= 1'b0;
         pend_q        <= '0;
         pend_pc_q     <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= RESET_PC;
         instr_valid_q <= 1'b0;
      end else begin
         if (instr_valid_q && !stall_i) instr_valid_q <= 1'b0;
         if (br_taken_i) begin
            instr_valid_q <= 1'b0;
            pc_q          <= tgt;
            // an issued request cannot be withdrawn, so its data is marked dead instead
            if (state_q == REQ && !imem.imem_ack) kill_q <= 1'b1;
            else begin
               kill_q     <= 1'b0;
               req_addr_q <= tgt;
               state_q    <= REQ;
               imem_req_q <= 1'b1;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  state_q    <= REQ;
                  req_addr_q <= pc_q;
                  imem_req_q <= 1'b1;
               end
               REQ: if (imem.imem_ack) begin
                  if (kill_q) begin
                     kill_q     <= 1'b0;
                     req_addr_q <= pc_q;
                  end else begin
                     pend_q     <= imem.imem_rdata;
                     pend_pc_q  <= req_addr_q;
                     pc_q       <= req_addr_q + XLEN'(4);
                     state_q    <= DELIVER;
                     imem_req_q <= 1'b0;
                  end
               end
               DELIVER: if (!instr_valid_q || !stall_i) begin
                  instr_q       <= pend_q;
                  instr_pc_q    <= pend_pc_q;
                  instr_valid_q <= 1'b1;
                  req_addr_q    <= pc_q;
                  state_q       <= REQ;
                  imem_req_q    <= 1'b1;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit; memory returns addr ^ A5A50000 unless a fixed word is forced.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n, ack, stall, br, use_fixed;
   logic [31:0] tgt, fixed;
   logic [31:0] instr, instr_pc, r15;
   logic        instr_valid;
   int          vecs = 0;
   int          errs = 0;
   always #5 clk = ~clk;
   fetch_unit_if #(.XLEN(32)) bus ();
   assign bus.imem_ack   = ack;
   assign bus.imem_rdata = use_fixed ? fixed : (bus.imem_addr ^ 32'hA5A5_0000);
   fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .imem(bus.master),
      .br_taken_i(br), .br_target_i(tgt), .stall_i(stall),
      .instr_o(instr), .instr_valid_o(instr_valid), .instr_pc_o(instr_pc), .r15_o(r15)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic bus_chk(input string tag, input logic req, input logic [31:0] addr);
      chk({tag, "_req"}, 32'(bus.imem_req), 32'(req));
      if (req) chk({tag, "_addr"}, bus.imem_addr, addr);
   endtask
   task automatic out_chk(input string tag, input logic v, input logic [31:0] pc);
      chk({tag, "_valid"}, 32'(instr_valid), 32'(v));
      if (v) begin
         chk({tag, "_pc"}, instr_pc, pc);
         chk({tag, "_r15"}, r15, pc + 32'd8);
      end
   endtask
   initial begin
      rst_n = 1'b0; ack = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0; use_fixed = 1'b0; fixed = '0;
      @(negedge clk);
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_r15", r15, 32'h8);
      rst_n = 1'b1; ack = 1'b1;
      @(negedge clk); bus_chk("t1_c1", 1'b1, 32'h0); out_chk("t1_c1", 1'b0, 32'h0);
      @(negedge clk); bus_chk("t1_c2", 1'b0, 32'h0); out_chk("t1_c2", 1'b0, 32'h0);
      @(negedge clk); bus_chk("t1_c3", 1'b1, 32'h4); out_chk("t1_c3", 1'b1, 32'h0);
      chk("t1_instr0", instr, 32'hA5A5_0000);
      @(negedge clk); out_chk("t1_c4", 1'b0, 32'h0);
      @(negedge clk); bus_chk("t1_c5", 1'b1, 32'h8); out_chk("t1_c5", 1'b1, 32'h4);
      @(negedge clk);
      @(negedge clk); bus_chk("t1_c7", 1'b1, 32'hC); out_chk("t1_c7", 1'b1, 32'h8);
      @(negedge clk); ack = 1'b0;
      @(negedge clk); bus_chk("t2_w1", 1'b1, 32'h10); out_chk("t2_w1", 1'b1, 32'hC);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); bus_chk("t2_wait", 1'b1, 32'h10);
      end
      @(negedge clk); bus_chk("t2_w4", 1'b1, 32'h10);
      ack = 1'b1; use_fixed = 1'b1; fixed = 32'hE3A0_1001;
      @(negedge clk); bus_chk("t2_ack", 1'b0, 32'h0);
      ack = 1'b0; use_fixed = 1'b0;
      @(negedge clk); out_chk("t2_dlv", 1'b1, 32'h10);
      chk("t2_instr", instr, 32'hE3A0_1001);
      stall = 1'b1; ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_instr", instr, 32'hE3A0_1001);
         out_chk("t3_hold", 1'b1, 32'h10);
         bus_chk("t3_noreq", 1'b0, 32'h0);
      end
      stall = 1'b0;
      @(negedge clk); out_chk("t3_resume", 1'b1, 32'h14); bus_chk("t3_resume", 1'b1, 32'h18);
      chk("t3_instr", instr, 32'hA5A5_0014);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); ack = 1'b0;
      @(negedge clk); bus_chk("t4_pre", 1'b1, 32'h20); out_chk("t4_pre", 1'b1, 32'h1C);
      br = 1'b1; tgt = 32'h103;
      @(negedge clk); br = 1'b0; bus_chk("t4_kill", 1'b1, 32'h20); out_chk("t4_kill", 1'b0, 32'h0);
      ack = 1'b1;
      @(negedge clk); bus_chk("t4_redir", 1'b1, 32'h100); out_chk("t4_redir", 1'b0, 32'h0);
      @(negedge clk); bus_chk("t4_fill", 1'b0, 32'h0); out_chk("t4_fill", 1'b0, 32'h0);
      @(negedge clk); out_chk("t4_dlv", 1'b1, 32'h100);
      chk("t4_instr", instr, 32'hA5A5_0100);
      @(negedge clk); bus_chk("t5_dlvst", 1'b0, 32'h0);
      br = 1'b1; tgt = 32'h41;
      @(negedge clk); bus_chk("t5_req40", 1'b1, 32'h40); out_chk("t5_req40", 1'b0, 32'h0);
      tgt = 32'h200;
      @(negedge clk); br = 1'b0; bus_chk("t5_req200", 1'b1, 32'h200); out_chk("t5_req200", 1'b0, 32'h0);
      @(negedge clk); out_chk("t5_fill", 1'b0, 32'h0);
      @(negedge clk); out_chk("t5_dlv", 1'b1, 32'h200); bus_chk("t5_next", 1'b1, 32'h204);
      chk("t5_instr", instr, 32'hA5A5_0200);
      br = 1'b1; tgt = 32'h80;
      @(negedge clk); br = 1'b0; ack = 1'b0; bus_chk("t6_req80", 1'b1, 32'h80);
      @(negedge clk); bus_chk("t6_wait80", 1'b1, 32'h80);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_req", 32'(bus.imem_req), 32'd0);
      chk("t6_addr", bus.imem_addr, 32'h0);
      chk("t6_valid", 32'(instr_valid), 32'd0);
      chk("t6_pc", instr_pc, 32'h0);
      chk("t6_r15", r15, 32'h8);
      chk("t6_instr", instr, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); bus_chk("t6_first", 1'b1, 32'h0);
      br = 1'b1; tgt = 32'hFFFF_FFFF; ack = 1'b1;
      @(negedge clk); br = 1'b0; bus_chk("t7_top", 1'b1, 32'hFFFF_FFFC);
      @(negedge clk); bus_chk("t7_fill", 1'b0, 32'h0);
      @(negedge clk); out_chk("t7_dlv", 1'b1, 32'hFFFF_FFFC); bus_chk("t7_wrap", 1'b1, 32'h0);
      chk("t7_r15wrap", r15, 32'h4);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
